lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller on the initiator side of the data memory: it accepts one CPU load or store request at a time and drives the memory's word-wide read and write ports. The memory is word-only, so this block adds byte and halfword support: it extracts and extends bytes and halfwords for loads, and performs sub-word stores as read-modify-write. It sits between the execute stage and the data memory and answers every accepted request with a single-cycle response pulse.

## Interface
- ADDR_WIDTH, default `DM_ADDR_WIDTH: byte-address width driven to the memory.
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept; a request is accepted when req_valid && req_ready.
- req_op  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address; only bits [ADDR_WIDTH-1:0] are used.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores.
- resp_exc  out  1  misalignment flag, valid with resp_valid.
- mem_read_addr  out  ADDR_WIDTH  byte address to the memory's asynchronous read port.
- mem_read_data  in  32  combinational read result.
- mem_write_addr  out  ADDR_WIDTH  byte address to the memory write port.
- mem_write_data  out  32  full word to write.
- mem_write_enable  out  1  active-high; the memory writes on the same posedge.

## Operation
- Four states: IDLE, EXEC, WRITE, DONE.
- **IDLE:** req_ready=1. On accept, latch op, addr and wdata, then go to EXEC. Without an accept, stay in IDLE.
- **EXEC:** mem_read_addr is the latched address.
  - Loads: take the addressed lane, extend it, and register the result into resp_rdata. Go to DONE.
  - SW: assert mem_write_enable with req_wdata, then go to DONE.
  - SH/SB: merge the new lane into mem_read_data, register the merged word, then go to WRITE.
- **WRITE:** assert mem_write_enable with the merged word, then go to DONE.
- **DONE:** resp_valid=1, req_ready=0, then go to IDLE.
- Byte lanes are little-endian: byte k is bits [8k+7:8k], k=addr[1:0]. A halfword at addr[1]=h occupies [16h+15:16h].
- Extension: LB and LH sign-extend; LBU and LHU zero-extend.
- mem_write_addr equals mem_read_addr. The write address must not change between the EXEC read and the WRITE write.
- mem_write_enable is 0 in IDLE and DONE, and 0 in any cycle where reset=1.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=0, mem_write_enable=0, mem_*_addr=0, mem_write_data=0.
- Latency from the accept edge (cycle 0):
  - Loads and SW: resp_valid in cycle 2.
  - SH/SB: resp_valid in cycle 3.
- Throughput: the next accept is possible in the cycle after DONE.
- req_ready is driven purely from state. It does not depend on req_valid.
- resp_rdata and resp_exc hold their values until the next response is written.
- Reset asserted in WRITE suppresses the write, returns to IDLE and produces no response.
- req_valid while busy is ignored; the CPU must hold the request until it is accepted.
- Address wrap: upper address bits are dropped silently. There is no out-of-range detection.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A word op with addr[1:0]!=0, or a halfword op with addr[0]!=0, goes EXEC→DONE without asserting mem_write_enable.
  - The response carries resp_exc=1 and resp_rdata=0.
- LSU_ALIGN_CHECK_EN undefined:
  - resp_exc is tied to 0.
  - The offending low address bits are forced to 0: word ops ignore addr[1:0], halfword ops ignore addr[0].

## Structure
- Shared header lsu.h holds:
  - the op encodings (LSU_OP_LW … LSU_OP_SB);
  - the state encodings (LSU_S_IDLE, LSU_S_EXEC, LSU_S_WRITE, LSU_S_DONE);
  - the helper predicates is_store and is_half.
- One combinational sub-module, lsu_lane, performs both lane functions:
  - load side: takes word, addr[1:0] and op, and returns the extended load value;
  - store side: takes old word, new data, addr[1:0] and op, and returns the merged word.

## Test plan
- Memory word 0x40 = 0x80FF7F01 → LB at 0x43 returns 0xFFFFFF80, LBU at 0x43 returns 0x00000080, LH at 0x42 returns 0xFFFF80FF. Each responds 2 cycles after accept.
- SB of 0xAB at 0x41 onto 0x11223344 → word becomes 0x1122AB44. resp_valid 3 cycles after accept; exactly one write pulse.
- Back-to-back: SW 0xDEADBEEF at 0x10 followed immediately by LW 0x10 → returns 0xDEADBEEF. req_ready is low for 2 cycles after each accept.
- With LSU_ALIGN_CHECK_EN: LW 0x42 → resp_exc=1, rdata=0; SH 0x41 → resp_exc=1, memory unchanged. Without the macro: LW 0x42 returns word 0x40.
- Reset pulsed while the state is WRITE during an SH → no write, no resp_valid, req_ready=1 in the following cycle.
- req_valid held high for 10 cycles with a fixed LW → exactly 3 accepts and 3 responses at cycles 2, 5 and 8.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
// Module : lsu_ctrl_pkg
// Brief  : Operation/state encodings and op-class predicates for lsu_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DM_ADDR_WIDTH
`define DM_ADDR_WIDTH 16
`endif

package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        LSU_OP_LW  = 3'b000,
        LSU_OP_LH  = 3'b001,
        LSU_OP_LHU = 3'b010,
        LSU_OP_LB  = 3'b011,
        LSU_OP_LBU = 3'b100,
        LSU_OP_SW  = 3'b101,
        LSU_OP_SH  = 3'b110,
        LSU_OP_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_S_IDLE  = 2'b00,
        LSU_S_EXEC  = 2'b01,
        LSU_S_WRITE = 2'b10,
        LSU_S_DONE  = 2'b11
    } lsu_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_OP_SW) || (op == LSU_OP_SH) || (op == LSU_OP_SB);
    endfunction

    function automatic logic is_half(input lsu_op_e op);
        return (op == LSU_OP_LH) || (op == LSU_OP_LHU) || (op == LSU_OP_SH);
    endfunction

    function automatic logic is_word(input lsu_op_e op);
        return (op == LSU_OP_LW) || (op == LSU_OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
// ============================================================================
// Module : lsu_ctrl_if
// Brief  : CPU request/response and data-memory port bundle for lsu_ctrl.
//          master = CPU + memory side, slave = the load/store controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DM_ADDR_WIDTH
`define DM_ADDR_WIDTH 16
`endif

interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = `DM_ADDR_WIDTH
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_exc;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [31:0]           mem_read_data;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [31:0]           mem_write_data;
    logic                  mem_write_enable;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_exc,
               mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_exc,
               mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );
endinterface

`default_nettype wire

// File: rtl/lsu_ctrl_lane.sv
// ============================================================================
// Module : lsu_lane
// Brief  : Combinational byte/halfword lane logic: load extract+extend and
//          sub-word store merge into the old memory word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_new,
    input  logic [1:0]  i_offset,
    input  lsu_op_e     i_op,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        case (i_op)
            LSU_OP_LW:  o_load = i_word;
            LSU_OP_LH:  o_load = {{16{w_half[15]}}, w_half};
            LSU_OP_LHU: o_load = {16'h0000, w_half};
            LSU_OP_LB:  o_load = {{24{w_byte[7]}}, w_byte};
            LSU_OP_LBU: o_load = {24'h000000, w_byte};
            default:    o_load = 32'h0000_0000;
        endcase

        o_merge = i_word;
        case (i_op)
            LSU_OP_SB: o_merge[{i_offset, 3'b000} +: 8]     = i_new[7:0];
            LSU_OP_SH: o_merge[{i_offset[1], 4'b0000} +: 16] = i_new[15:0];
            default:   o_merge = i_new;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module : lsu_ctrl
// Brief  : Single-outstanding load/store controller in front of a word-only
//          data memory; sub-word stores are done as read-modify-write.
//          Optional macro LSU_ALIGN_CHECK_EN: flag misaligned accesses
//          instead of silently aligning them.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = `DM_ADDR_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    lsu_ctrl_if.slave bus
);

    lsu_state_e            state_q, state_d;
    lsu_op_e               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  exc_q, exc_d;
    logic                  misal_q, misal_d;
    logic                  we_q, we_d;

    lsu_op_e               w_req_op;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_req_misal;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merge_data;

    assign w_req_op = lsu_op_e'(bus.req_op);

    generate
        if (ADDR_WIDTH < 32) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^bus.req_addr[31:ADDR_WIDTH];
        end
    endgenerate

    // Alignment is resolved once at accept so EXEC sees a final address.
    always_comb begin
        w_req_addr  = bus.req_addr[ADDR_WIDTH-1:0];
        w_req_misal = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        w_req_misal = (is_word(w_req_op) && (w_req_addr[1:0] != 2'b00)) ||
                      (is_half(w_req_op) && w_req_addr[0]);
`else
        if (is_word(w_req_op)) begin
            w_req_addr[1:0] = 2'b00;
        end else if (is_half(w_req_op)) begin
            w_req_addr[0] = 1'b0;
        end
`endif
    end

    lsu_lane u_lane (
        .i_word   (bus.mem_read_data),
        .i_new    (wdata_q),
        .i_offset (addr_q[1:0]),
        .i_op     (op_q),
        .o_load   (w_load_data),
        .o_merge  (w_merge_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        misal_d = misal_q;
        we_d    = 1'b0;
        case (state_q)
            LSU_S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = w_req_op;
                    addr_d  = w_req_addr;
                    wdata_d = bus.req_wdata;
                    misal_d = w_req_misal;
                    // SW writes during EXEC, so its enable is raised at accept.
                    we_d    = (w_req_op == LSU_OP_SW) && !w_req_misal;
                    state_d = LSU_S_EXEC;
                end
            end
            LSU_S_EXEC: begin
                exc_d   = misal_q;
                rdata_d = 32'h0000_0000;
                state_d = LSU_S_DONE;
                if (!misal_q) begin
                    if (!is_store(op_q)) begin
                        rdata_d = w_load_data;
                    end else if (op_q != LSU_OP_SW) begin
                        wdata_d = w_merge_data;
                        we_d    = 1'b1;
                        state_d = LSU_S_WRITE;
                    end
                end
            end
            LSU_S_WRITE: state_d = LSU_S_DONE;
            LSU_S_DONE:  state_d = LSU_S_IDLE;
            default:     state_d = LSU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LSU_S_IDLE;
            op_q    <= LSU_OP_LW;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            exc_q   <= 1'b0;
            misal_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            misal_q <= misal_d;
            we_q    <= we_d;
        end
    end

    assign bus.req_ready        = (state_q == LSU_S_IDLE);
    assign bus.resp_valid       = (state_q == LSU_S_DONE);
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_exc         = exc_q;
    assign bus.mem_read_addr    = addr_q;
    assign bus.mem_write_addr   = addr_q;
    assign bus.mem_write_data   = wdata_q;
    // The enable is a flop; reset must still kill an in-flight write at once.
    assign bus.mem_write_enable = we_q && !reset;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module : tb_lsu_ctrl
// Brief  : Directed self-checking bench for lsu_ctrl with a word memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    localparam int AW = 16;
    localparam logic [2:0] C_OP_LW  = 3'b000;
    localparam logic [2:0] C_OP_LH  = 3'b001;
    localparam logic [2:0] C_OP_LHU = 3'b010;
    localparam logic [2:0] C_OP_LB  = 3'b011;
    localparam logic [2:0] C_OP_LBU = 3'b100;
    localparam logic [2:0] C_OP_SW  = 3'b101;
    localparam logic [2:0] C_OP_SH  = 3'b110;
    localparam logic [2:0] C_OP_SB  = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [31:0]   mem [0:(1<<(AW-2))-1];
    logic          poke_en = 1'b0;
    logic [AW-3:0] poke_idx = '0;
    logic [31:0]   poke_data = '0;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    lsu_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_read_data = mem[bus.mem_read_addr[AW-1:2]];

    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_write_addr[AW-1:2]] <= bus.mem_write_data;
        else if (poke_en)         mem[poke_idx] <= poke_data;
    end

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = addr[AW-1:2];
        poke_data = data;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request from a negedge; returns at the negedge of the response cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic exc,
                          output int lat, output int nwr, output int nbusy);
        int guard;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nwr = 0; nbusy = 0; rdata = 'x; exc = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_write_enable) nwr++;
            if (!bus.req_ready) nbusy++;
            if (bus.resp_valid) begin
                lat = c; rdata = bus.resp_rdata; exc = bus.resp_exc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = C_OP_LW; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        if (bus.resp_exc !== 1'b0) begin errors++; $display("FAIL rst_exc: got %b want 0", bus.resp_exc); end
        if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_write_enable); end
        if (bus.mem_read_addr !== '0 || bus.mem_write_addr !== '0) begin
            errors++; $display("FAIL rst_addr: got %h/%h want 0/0", bus.mem_read_addr, bus.mem_write_addr);
        end
        if (bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_write_data); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic ex; int lat, nwr, nb;
        logic [2:0]  ops  [6] = '{C_OP_LB, C_OP_LBU, C_OP_LH, C_OP_LHU, C_OP_LB, C_OP_LW};
        logic [31:0] adrs [6] = '{32'h43, 32'h43, 32'h42, 32'h42, 32'h41, 32'h40};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                  32'h0000007F, 32'h80FF7F01};
        poke(32'h40, 32'h80FF7F01);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], adrs[i], 32'h0, rd, ex, lat, nwr, nb);
            checks += 3;
            if (rd !== exps[i]) begin errors++; $display("FAIL load_data[%0d]: got %h want %h", i, rd, exps[i]); end
            if (lat != 2) begin errors++; $display("FAIL load_latency[%0d]: got %0d want 2", i, lat); end
            if (nwr != 0 || ex !== 1'b0) begin
                errors++; $display("FAIL load_side[%0d]: writes=%0d exc=%b want 0/0", i, nwr, ex);
            end
        end
    endtask

    task automatic test_store_sub();
        logic [31:0] rd; logic ex; int lat, nwr, nb;
        poke(32'h40, 32'h11223344);
        @(negedge clk);
        run_op(C_OP_SB, 32'h41, 32'hFFFF_FFAB, rd, ex, lat, nwr, nb);
        checks += 4;
        if (lat != 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
        if (nwr != 1) begin errors++; $display("FAIL sb_write_pulses: got %0d want 1", nwr); end
        if (rd !== 32'h0 || ex !== 1'b0) begin errors++; $display("FAIL sb_resp: rdata=%h exc=%b want 0/0", rd, ex); end
        if (mem[32'h40 >> 2] !== 32'h1122AB44) begin
            errors++; $display("FAIL sb_mem: got %h want 1122AB44", mem[32'h40 >> 2]);
        end
        @(negedge clk);
        run_op(C_OP_SH, 32'h42, 32'h1234_BEEF, rd, ex, lat, nwr, nb);
        checks += 2;
        if (lat != 3 || nwr != 1) begin errors++; $display("FAIL sh_timing: lat=%0d writes=%0d want 3/1", lat, nwr); end
        if (mem[32'h40 >> 2] !== 32'hBEEFAB44) begin
            errors++; $display("FAIL sh_mem: got %h want BEEFAB44", mem[32'h40 >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ex; int lat, nwr, nb;
        @(negedge clk);
        run_op(C_OP_SW, 32'h10, 32'hDEADBEEF, rd, ex, lat, nwr, nb);
        checks += 2;
        if (lat != 2 || nwr != 1) begin errors++; $display("FAIL sw_timing: lat=%0d writes=%0d want 2/1", lat, nwr); end
        if (nb != 2) begin errors++; $display("FAIL sw_busy: ready low %0d cycles want 2", nb); end
        run_op(C_OP_LW, 32'h10, 32'h0, rd, ex, lat, nwr, nb);
        checks += 3;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_lw_data: got %h want DEADBEEF", rd); end
        if (lat != 2) begin errors++; $display("FAIL b2b_lw_latency: got %0d want 2", lat); end
        if (nb != 2) begin errors++; $display("FAIL lw_busy: ready low %0d cycles want 2", nb); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic ex; int lat, nwr, nb;
        poke(32'h40, 32'h12345678);
        @(negedge clk);
        run_op(C_OP_LW, 32'h42, 32'h0, rd, ex, lat, nwr, nb);
`ifdef LSU_ALIGN_CHECK_EN
        checks += 2;
        if (ex !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign: exc=%b rdata=%h want 1/0", ex, rd); end
        if (lat != 2) begin errors++; $display("FAIL lw_misalign_latency: got %0d want 2", lat); end
        @(negedge clk);
        run_op(C_OP_SH, 32'h41, 32'h0000BEEF, rd, ex, lat, nwr, nb);
        checks += 3;
        if (ex !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_misalign: exc=%b rdata=%h want 1/0", ex, rd); end
        if (nwr != 0 || lat != 2) begin errors++; $display("FAIL sh_misalign_timing: writes=%0d lat=%0d want 0/2", nwr, lat); end
        if (mem[32'h40 >> 2] !== 32'h12345678) begin
            errors++; $display("FAIL sh_misalign_mem: got %h want 12345678", mem[32'h40 >> 2]);
        end
`else
        checks += 1;
        if (ex !== 1'b0 || rd !== 32'h12345678) begin
            errors++; $display("FAIL lw_forced_align: exc=%b rdata=%h want 0/12345678", ex, rd);
        end
        @(negedge clk);
        run_op(C_OP_SH, 32'h41, 32'h0000BEEF, rd, ex, lat, nwr, nb);
        checks += 2;
        if (ex !== 1'b0 || nwr != 1) begin errors++; $display("FAIL sh_forced_align: exc=%b writes=%0d want 0/1", ex, nwr); end
        if (mem[32'h40 >> 2] !== 32'h1234BEEF) begin
            errors++; $display("FAIL sh_forced_align_mem: got %h want 1234BEEF", mem[32'h40 >> 2]);
        end
`endif
        // Upper address bits beyond the memory width are dropped.
        poke(32'h40, 32'hA5A55A5A);
        @(negedge clk);
        run_op(C_OP_LW, 32'hFFFF_0040, 32'h0, rd, ex, lat, nwr, nb);
        checks += 1;
        if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL addr_wrap: got %h want A5A55A5A", rd); end
    endtask

    task automatic test_reset_in_write();
        int resp_seen;
        poke(32'h40, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = C_OP_SH; bus.req_addr = 32'h42; bus.req_wdata = 32'h5555;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks += 1;
        if (bus.mem_write_enable !== 1'b1) begin
            errors++; $display("FAIL rw_pre_we: got %b want 1", bus.mem_write_enable);
        end
        reset = 1'b1;
        #1;
        checks += 1;
        if (bus.mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL rw_we_in_reset: got %b want 0", bus.mem_write_enable);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 1;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b want 1", bus.req_ready); end
        resp_seen = bus.resp_valid ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen++;
        end
        checks += 2;
        if (resp_seen != 0) begin errors++; $display("FAIL rw_resp: got %0d responses want 0", resp_seen); end
        if (mem[32'h40 >> 2] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rw_mem: got %h want CAFEF00D", mem[32'h40 >> 2]);
        end
    endtask

    task automatic test_hold_valid();
        int          acc;
        logic [12:0] resp_mask;
        int          bad_data;
        acc = 0; resp_mask = '0; bad_data = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = C_OP_LW; bus.req_addr = 32'h10; bus.req_wdata = '0;
        for (int p = 0; p < 12; p++) begin
            if (bus.req_valid && bus.req_ready) acc++;
            @(posedge clk);
            #1;
            if (p == 8) bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.resp_valid) begin
                resp_mask[p+1] = 1'b1;
                if (bus.resp_rdata !== 32'hDEADBEEF) bad_data++;
            end
        end
        checks += 3;
        if (acc != 3) begin errors++; $display("FAIL hold_accepts: got %0d want 3", acc); end
        if (resp_mask !== 13'h0124) begin errors++; $display("FAIL hold_resp_cycles: got %b want 0000100100100", resp_mask); end
        if (bad_data != 0) begin errors++; $display("FAIL hold_data: %0d responses not DEADBEEF", bad_data); end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_sub();
        test_back_to_back();
        test_align();
        test_reset_in_write();
        test_hold_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
